tdc_frame_ctrl: RTL

Frame scheduler for the TDC/histogram datapath. Issues periodic one-cycle `TDC_start` pulses to `tdc_top` and counts shots per frame. Drives the histogram batch configuration, collects the histogram peak over the `HIS_Ovalid`/`HIS_Oready` handshake, and hands one result per frame to core logic over a valid/ready output. It replaces the free-running start counter currently hand-built in benches and core logic.

---
 rtl/tdc_pkg.sv | 12 +
 rtl/tdc_shot_timer.sv | 52 +++++
 rtl/tdc_frame_ctrl.sv | 94 +++++++++
 3 files changed

// File: rtl/tdc_pkg.sv
// tdc_pkg: shared state encoding and constants for the TDC frame scheduler
package tdc_pkg;
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_SHOT = 3'd2,
    ST_WAIT = 3'd3,
    ST_OUT  = 3'd4
  } state_t;
  localparam logic [14:0] TIMEOUT_CODE = 15'h7FFF;
  localparam int MIN_PERIOD_DEF = 16;
endpackage

// File: rtl/tdc_shot_timer.sv
// tdc_shot_timer: shot period counter with busy deferral, registered start pulse decided one cycle ahead, and per-frame shot counter
module tdc_shot_timer import tdc_pkg::*; #(
  parameter int PERIOD_W   = 20,
  parameter int SHOT_W     = 16,
  parameter int MIN_PERIOD = MIN_PERIOD_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                run,
  input  logic                busy,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic [SHOT_W-1:0]   cfg_shots,
  output logic                start_pulse,
  output logic                last_shot_done,
  output logic [SHOT_W-1:0]   shots_lat
);
  localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);
  logic [PERIOD_W-1:0] p_eff, p_last, cnt;
  logic [SHOT_W-1:0] n_eff, shot_cnt;
  logic slot, fire;
  always_comb begin
    p_eff = cfg_period < MIN_P ? MIN_P : cfg_period;
    n_eff = cfg_shots == '0 ? SHOT_W'(1) : cfg_shots;
    slot = cnt == p_last;
    fire = run && slot && !busy && shot_cnt != shots_lat;
    last_shot_done = run && slot && shot_cnt == shots_lat;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_last      <= '0;
      cnt         <= '0;
      shot_cnt    <= '0;
      shots_lat   <= '0;
      start_pulse <= 1'b0;
    end else if (load) begin
      p_last      <= p_eff - 1'b1;
      cnt         <= busy ? p_eff - 1'b1 : '0;
      shot_cnt    <= busy ? '0 : SHOT_W'(1);
      shots_lat   <= n_eff;
      start_pulse <= !busy;
    end else begin
      start_pulse <= fire;
      if (fire) begin
        cnt      <= '0;
        shot_cnt <= shot_cnt + 1'b1;
      end else if (run && !slot) begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/tdc_frame_ctrl.sv
// tdc_frame_ctrl: frame FSM issuing TDC starts, collecting the histogram peak and handing one result per frame to core logic
module tdc_frame_ctrl import tdc_pkg::*; #(
  parameter int PERIOD_W   = 20,
  parameter int SHOT_W     = 16,
  parameter int TO_W       = 16,
  parameter int MIN_PERIOD = MIN_PERIOD_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_en,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic [SHOT_W-1:0]   cfg_shots,
  input  logic [TO_W-1:0]     cfg_timeout,
  input  logic                busy,
  output logic                TDC_start,
  output logic                HIS_En,
  output logic [SHOT_W-1:0]   HIS_Ibatch,
  input  logic [14:0]         HIS_Odata,
  input  logic                HIS_Ovalid,
  output logic                HIS_Oready,
  output logic [14:0]         frm_data,
  output logic                frm_err,
  output logic                frm_valid,
  input  logic                frm_ready,
  output logic [SHOT_W-1:0]   frm_cnt
);
  state_t st, nxt;
  logic [TO_W-1:0] to_lat, to_cnt;
  logic last_shot_done, hs, tmo;
  tdc_shot_timer #(
    .PERIOD_W  (PERIOD_W),
    .SHOT_W    (SHOT_W),
    .MIN_PERIOD(MIN_PERIOD)
  ) u_timer (
    .clk           (clk),
    .rst_n         (rst_n),
    .load          (st == ST_ARM),
    .run           (st == ST_SHOT),
    .busy          (busy),
    .cfg_period    (cfg_period),
    .cfg_shots     (cfg_shots),
    .start_pulse   (TDC_start),
    .last_shot_done(last_shot_done),
    .shots_lat     (HIS_Ibatch)
  );
  always_comb begin
    hs  = HIS_Ovalid && HIS_Oready;
    tmo = to_lat != '0 && to_cnt == to_lat;
    nxt = st;
    case (st)
      ST_IDLE: nxt = cfg_en ? ST_ARM : ST_IDLE;
      ST_ARM:  nxt = ST_SHOT;
      ST_SHOT: nxt = last_shot_done ? ST_WAIT : ST_SHOT;
      ST_WAIT: nxt = (hs || tmo) ? ST_OUT : ST_WAIT;
      ST_OUT:  nxt = (frm_valid && frm_ready) ? (cfg_en ? ST_ARM : ST_IDLE) : ST_OUT;
      default: nxt = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= ST_IDLE;
    else st <= nxt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      HIS_En     <= 1'b0;
      HIS_Oready <= 1'b0;
      frm_valid  <= 1'b0;
      frm_data   <= '0;
      frm_err    <= 1'b0;
      frm_cnt    <= '0;
      to_lat     <= '0;
      to_cnt     <= '0;
    end else begin
      HIS_En     <= nxt == ST_ARM || nxt == ST_SHOT || nxt == ST_WAIT;
      HIS_Oready <= nxt == ST_WAIT;
      frm_valid  <= nxt == ST_OUT;
      if (st == ST_ARM) begin
        to_lat <= cfg_timeout;
        to_cnt <= '0;
      end else if (st == ST_WAIT) begin
        if (hs) begin
          frm_data <= HIS_Odata;
          frm_err  <= 1'b0;
        end else if (tmo) begin
          frm_data <= TIMEOUT_CODE;
          frm_err  <= 1'b1;
        end else if (to_cnt != '1) begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
      if (frm_valid && frm_ready) frm_cnt <= frm_cnt + 1'b1;
    end
  end
endmodule
